// File: rtl/ysyx_24080014_fetch_ctrl_if.sv
// Read-channel bundle between the fetch controller (master) and instruction memory (slave).
interface ysyx_24080014_fetch_ctrl_if;
   logic        arvalid;
   logic [31:0] araddr;
   logic        arready;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rready;

   modport master (
      output arvalid, araddr, rready,
      input  arready, rvalid, rdata, rresp
   );

   modport slave (
      input  arvalid, araddr, rready,
      output arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/ysyx_24080014_fetch_ctrl.sv
// PC register and single-outstanding instruction fetch sequencer for the multi-cycle core.
// Buffers one instruction for the IDU, then waits for the committed next PC or a redirect.
module ysyx_24080014_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h8000_0000,
   parameter int          TIMEOUT_CYC = 1024,
   parameter int          CNT_W       = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   ysyx_24080014_fetch_ctrl_if.master bus,
   output logic [31:0]          pc,
   output logic                 inst_valid,
   output logic [31:0]          inst,
   output logic                 inst_fault,
   input  logic                 inst_ready,
   input  logic                 npc_valid,
   input  logic [31:0]          npc,
   input  logic                 redirect_valid,
   input  logic [31:0]          redirect_pc,
   output logic                 fetch_timeout,
   output logic [CNT_W-1:0]     fetch_cnt
);

   localparam int WC_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [WC_W-1:0] TO_LIM = WC_W'(TIMEOUT_CYC);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_DLVR, S_WNPC} state_t;

   state_t          state, state_nxt;
   logic [31:0]     pc_nxt;
   logic            pc_ld;
   logic            redir_pend;
   logic [31:0]     redir_pc;
   logic            pend_set, pend_clr;
   logic            resp_take, fault_ld, handoff;
   logic            wait_clr, wait_inc, to_hit;
   logic [WC_W-1:0] wait_cnt;
   logic            fault_q;
   logic            misaligned;

   assign misaligned = |pc[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      pc_ld       = 1'b0;
      pc_nxt      = pc;
      pend_set    = 1'b0;
      pend_clr    = 1'b0;
      resp_take   = 1'b0;
      fault_ld    = 1'b0;
      handoff     = 1'b0;
      wait_clr    = 1'b0;
      wait_inc    = 1'b0;
      to_hit      = 1'b0;
      bus.arvalid = 1'b0;
      bus.araddr  = pc;
      bus.rready  = 1'b0;
      inst_valid  = 1'b0;
      inst_fault  = 1'b0;
      case (state)
         S_IDLE: begin
            state_nxt = S_REQ;
            if (redirect_valid) begin
               pc_ld  = 1'b1;
               pc_nxt = redirect_pc;
            end
         end
         S_REQ: begin
            if (misaligned) begin
               // No request is issued yet, so a redirect can take effect immediately.
               if (redirect_valid) begin
                  pc_ld  = 1'b1;
                  pc_nxt = redirect_pc;
               end else begin
                  fault_ld  = 1'b1;
                  state_nxt = S_DLVR;
               end
            end else begin
               bus.arvalid = 1'b1;
               pend_set    = redirect_valid;
               if (bus.arready) begin
                  wait_clr  = 1'b1;
                  state_nxt = S_RESP;
               end
            end
         end
         S_RESP: begin
            bus.rready = 1'b1;
            if (bus.rvalid) begin
               // A redirect seen now or earlier discards this response.
               if (redirect_valid || redir_pend) begin
                  pc_ld     = 1'b1;
                  pc_nxt    = redirect_valid ? redirect_pc : redir_pc;
                  pend_clr  = 1'b1;
                  state_nxt = S_REQ;
               end else begin
                  resp_take = 1'b1;
                  state_nxt = S_DLVR;
               end
            end else begin
               pend_set = redirect_valid;
               wait_inc = (wait_cnt != TO_LIM);
               to_hit   = wait_inc && (wait_cnt == TO_LIM - WC_W'(1));
            end
         end
         S_DLVR: begin
            inst_valid = 1'b1;
            inst_fault = fault_q;
            if (redirect_valid) begin
               pc_ld     = 1'b1;
               pc_nxt    = redirect_pc;
               state_nxt = S_REQ;
            end else if (inst_ready) begin
               handoff   = 1'b1;
               state_nxt = S_WNPC;
            end
         end
         S_WNPC: begin
            if (redirect_valid) begin
               pc_ld     = 1'b1;
               pc_nxt    = redirect_pc;
               state_nxt = S_REQ;
            end else if (npc_valid) begin
               pc_ld     = 1'b1;
               pc_nxt    = npc;
               state_nxt = S_REQ;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc            <= RESET_PC;
         inst          <= '0;
         fault_q       <= 1'b0;
         redir_pend    <= 1'b0;
         redir_pc      <= '0;
         wait_cnt      <= '0;
         fetch_timeout <= 1'b0;
         fetch_cnt     <= '0;
      end else begin
         if (pc_ld) pc <= pc_nxt;
         if (fault_ld) begin
            inst    <= '0;
            fault_q <= 1'b1;
         end else if (resp_take) begin
            inst    <= (|bus.rresp) ? 32'h0 : bus.rdata;
            fault_q <= |bus.rresp;
         end
         // Newest redirect target overwrites any earlier pending one.
         if (pend_set) begin
            redir_pend <= 1'b1;
            redir_pc   <= redirect_pc;
         end else if (pend_clr) begin
            redir_pend <= 1'b0;
         end
         if (wait_clr)      wait_cnt <= '0;
         else if (wait_inc) wait_cnt <= wait_cnt + WC_W'(1);
         if (to_hit)  fetch_timeout <= 1'b1;
         if (handoff) fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ysyx_24080014_fetch_ctrl.sv
// Directed bench for the fetch controller: handshake latency, faults, redirects, timeout, counter wrap.
module tb_ysyx_24080014_fetch_ctrl;

   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic [31:0]   pc;
   logic          inst_valid;
   logic [31:0]   inst;
   logic          inst_fault;
   logic          inst_ready;
   logic          npc_valid;
   logic [31:0]   npc;
   logic          redirect_valid;
   logic [31:0]   redirect_pc;
   logic          fetch_timeout;
   logic [CW-1:0] fetch_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   ysyx_24080014_fetch_ctrl_if bus ();

   ysyx_24080014_fetch_ctrl #(
      .RESET_PC    (32'h8000_0000),
      .TIMEOUT_CYC (4),
      .CNT_W       (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus),
      .pc             (pc),
      .inst_valid     (inst_valid),
      .inst           (inst),
      .inst_fault     (inst_fault),
      .inst_ready     (inst_ready),
      .npc_valid      (npc_valid),
      .npc            (npc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_timeout  (fetch_timeout),
      .fetch_cnt      (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic accept();
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data, input logic [1:0] resp);
      bus.rvalid = 1'b1;
      bus.rdata  = data;
      bus.rresp  = resp;
      tick();
      bus.rvalid = 1'b0;
      bus.rresp  = 2'b00;
   endtask

   task automatic handoff();
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   task automatic commit(input logic [31:0] next);
      npc_valid = 1'b1;
      npc       = next;
      tick();
      npc_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      rst = 1'b0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
      inst_ready = 1'b0; npc_valid = 1'b0; npc = '0;
      redirect_valid = 1'b0; redirect_pc = '0;
      tick(); tick();

      // reset state
      chk ("rst_pc",      pc, 32'h8000_0000);
      chkb("rst_arvalid", bus.arvalid, 1'b0);
      chkb("rst_rready",  bus.rready, 1'b0);
      chkb("rst_ivalid",  inst_valid, 1'b0);
      chkb("rst_ifault",  inst_fault, 1'b0);
      chk ("rst_inst",    inst, 32'h0);
      chkb("rst_timeout", fetch_timeout, 1'b0);
      chk ("rst_cnt",     32'(fetch_cnt), 32'd0);

      rst = 1'b1;
      tick();
      chkb("c1_arvalid", bus.arvalid, 1'b1);
      chk ("c1_araddr",  bus.araddr, 32'h8000_0000);
      accept();
      chkb("c2_rready",  bus.rready, 1'b1);
      chkb("c2_arvalid", bus.arvalid, 1'b0);
      respond(32'h0000_0413, 2'b00);
      chkb("c3_ivalid",  inst_valid, 1'b1);
      chk ("c3_inst",    inst, 32'h0000_0413);
      chkb("c3_ifault",  inst_fault, 1'b0);
      handoff();
      chkb("wnpc_ivalid", inst_valid, 1'b0);
      chk ("cnt1",        32'(fetch_cnt), 32'd1);
      commit(32'h8000_0004);
      chkb("f2_arvalid", bus.arvalid, 1'b1);
      chk ("f2_araddr",  bus.araddr, 32'h8000_0004);

      // bus error response
      accept();
      respond(32'h1234_5678, 2'b10);
      chkb("berr_ivalid", inst_valid, 1'b1);
      chkb("berr_fault",  inst_fault, 1'b1);
      handoff();
      commit(32'h8000_0006);

      // misaligned pc: no request, faulted delivery
      chkb("mis_arvalid", bus.arvalid, 1'b0);
      chk ("mis_pc",      pc, 32'h8000_0006);
      tick();
      chkb("mis_ivalid",  inst_valid, 1'b1);
      chkb("mis_fault",   inst_fault, 1'b1);
      chk ("mis_inst",    inst, 32'h0);
      handoff();
      chk ("cnt3",        32'(fetch_cnt), 32'd3);
      commit(32'h8000_0008);
      chk ("f4_araddr",   bus.araddr, 32'h8000_0008);

      // redirect during RESP; late response discarded
      accept();
      redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
      tick();
      redirect_valid = 1'b0;
      tick(); tick();
      chkb("rresp_wait",  bus.rready, 1'b1);
      respond(32'hDEAD_BEEF, 2'b00);
      chkb("rdr_ivalid",  inst_valid, 1'b0);
      chkb("rdr_arvalid", bus.arvalid, 1'b1);
      chk ("rdr_araddr",  bus.araddr, 32'h8000_1000);
      chk ("rdr_inst",    inst, 32'h0);
      chk ("rdr_cnt",     32'(fetch_cnt), 32'd3);

      // arready stalled 5 cycles, redirect in cycle 2
      tick();
      chk ("stall1_addr", bus.araddr, 32'h8000_1000);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
      tick();
      redirect_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chkb("stall_arvalid", bus.arvalid, 1'b1);
         chk ("stall_addr",    bus.araddr, 32'h8000_1000);
         tick();
      end
      accept();
      respond(32'h1111_1111, 2'b00);
      chkb("stall_ivalid", inst_valid, 1'b0);
      chk ("stall_target", bus.araddr, 32'h8000_2000);

      // response timeout with TIMEOUT_CYC=4
      accept();
      for (int i = 0; i < 3; i++) begin
         tick();
         chkb("to_early", fetch_timeout, 1'b0);
      end
      tick();
      chkb("to_rise", fetch_timeout, 1'b1);
      for (int i = 0; i < 6; i++) tick();
      chkb("to_sticky", fetch_timeout, 1'b1);
      respond(32'hCAFE_0013, 2'b00);
      chkb("to_ivalid", inst_valid, 1'b1);
      chk ("to_inst",   inst, 32'hCAFE_0013);
      handoff();
      chk ("cnt4",      32'(fetch_cnt), 32'd4);

      // redirect beats npc_valid in WNPC
      redirect_valid = 1'b1; redirect_pc = 32'h8000_3000;
      npc_valid = 1'b1; npc = 32'h8000_9000;
      tick();
      redirect_valid = 1'b0; npc_valid = 1'b0;
      chk ("wn_rdr_pc",  pc, 32'h8000_3000);
      chkb("wn_timeout", fetch_timeout, 1'b1);

      // redirect in DLVR alongside inst_ready: no count
      accept();
      respond(32'h0000_0013, 2'b00);
      inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_4000;
      tick();
      inst_ready = 1'b0; redirect_valid = 1'b0;
      chk ("dl_rdr_addr",  bus.araddr, 32'h8000_4000);
      chkb("dl_rdr_ivld",  inst_valid, 1'b0);
      chk ("dl_rdr_cnt",   32'(fetch_cnt), 32'd4);

      // asynchronous reset mid-transaction
      accept();
      rst = 1'b0;
      #1;
      chkb("arst_rready",  bus.rready, 1'b0);
      chk ("arst_pc",      pc, 32'h8000_0000);
      chkb("arst_timeout", fetch_timeout, 1'b0);
      chk ("arst_cnt",     32'(fetch_cnt), 32'd0);
      tick();
      rst = 1'b1;
      tick();

      // 17 fetches wrap a 4-bit counter to 1
      a = 32'h8000_0000;
      for (int i = 0; i < 17; i++) begin
         chk("wrap_addr", bus.araddr, a);
         accept();
         respond(32'(i), 2'b00);
         handoff();
         if (i == 15) chk("wrap_zero", 32'(fetch_cnt), 32'd0);
         a = a + 32'd4;
         commit(a);
      end
      chk("wrap_one", 32'(fetch_cnt), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
